// File: rtl/data_mem_responder_pkg.sv
// Shared state encoding, default sizing and the address range helper
// for the data memory responder and its storage array.
package data_mem_responder_pkg;

  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unsigned compare over the full 8-bit address.
  function automatic logic addrInRange(input logic [7:0] addr, input int depth);
    return (int'({24'd0, addr}) < depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between a requester (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic       busy;
  logic       err;

  modport master (output req, we, addr, wdata, input rdata, ack, busy, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x 8 storage with one synchronous write port and one synchronous
// read port; deliberately unreset so contents survive a block reset.
module data_mem_array #(
  parameter int DEPTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state memory responder: captures one request in IDLE, counts
// WAIT_CYCLES wait states, then presents a one-cycle ack with data/err.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int DEPTH       = DEFAULT_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t     r_state, w_nextState;
  logic [3:0] r_count, w_nextCount;
  logic       r_we;
  logic [7:0] r_addr, r_wdata, r_rdataHold;

  logic       w_capture, w_enterResp, w_curWe, w_curInRange;
  logic [7:0] w_curAddr, w_curWdata, w_memRdata, w_respData;

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_capture   = 1'b1;
          w_nextCount = CNT_LOAD;
          w_nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_count == 4'd0) w_nextState = RESP;
        else                 w_nextCount = r_count - 4'd1;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // With zero wait states the RESP-entry edge is the capture edge itself,
  // so the memory must see the live request rather than the captured copy.
  assign w_curWe      = (r_state == IDLE) ? bus.we    : r_we;
  assign w_curAddr    = (r_state == IDLE) ? bus.addr  : r_addr;
  assign w_curWdata   = (r_state == IDLE) ? bus.wdata : r_wdata;
  assign w_curInRange = addrInRange(w_curAddr, DEPTH);
  assign w_enterResp  = (w_nextState == RESP) && !reset;

  data_mem_array #(.DEPTH(DEPTH)) u_array (
    .clock   (clock),
    .i_we    (w_enterResp && w_curWe && w_curInRange),
    .i_re    (w_enterResp && !w_curWe && w_curInRange),
    .i_addr  (w_curAddr[AW-1:0]),
    .i_wdata (w_curWdata),
    .o_rdata (w_memRdata)
  );

  assign w_respData = !addrInRange(r_addr, DEPTH) ? 8'h00 :
                      (r_we ? r_rdataHold : w_memRdata);

  assign bus.rdata = (r_state == RESP) ? w_respData : r_rdataHold;
  assign bus.ack   = (r_state == RESP);
  assign bus.busy  = (r_state != IDLE);
  assign bus.err   = (r_state == RESP) && !addrInRange(r_addr, DEPTH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_rdataHold <= 8'h00;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (w_capture) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (r_state == RESP) r_rdataHold <= w_respData;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for two responder instances
// (two wait states and zero wait states) against a flat memory model.
module tb_data_mem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_mem_responder_if busA ();
  data_mem_responder_if busB ();

  data_mem_responder #(.WAIT_CYCLES(2), .DEPTH(64)) dutA (.clock(clock), .reset(reset), .bus(busA));
  data_mem_responder #(.WAIT_CYCLES(0), .DEPTH(64)) dutB (.clock(clock), .reset(reset), .bus(busB));

  int vectorCount = 0;
  int missCount   = 0;

  logic [7:0] mdl [2][64];
  logic [7:0] lastRdata [2];
  bit         curSel = 1'b0;

  logic [7:0] obsRdata;
  logic       obsAck, obsBusy, obsErr;
  assign obsRdata = curSel ? busB.rdata : busA.rdata;
  assign obsAck   = curSel ? busB.ack   : busA.ack;
  assign obsBusy  = curSel ? busB.busy  : busA.busy;
  assign obsErr   = curSel ? busB.err   : busA.err;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectorCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic driveBus(input bit sel, input logic req, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata);
    if (sel) begin
      busB.req = req; busB.we = we; busB.addr = addr; busB.wdata = wdata;
    end else begin
      busA.req = req; busA.we = we; busA.addr = addr; busA.wdata = wdata;
    end
  endtask

  // One access: glitch pulses a conflicting write request during the wait states.
  task automatic applyStimulus(input bit sel, input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, input bit glitch);
    int         w;
    bit         oor;
    logic [7:0] exp;
    w      = sel ? 0 : 2;
    oor    = (addr >= 8'd64);
    curSel = sel;
    if (oor)     exp = 8'h00;
    else if (we) exp = lastRdata[sel];
    else         exp = mdl[sel][addr[5:0]];
    if (!oor && we) mdl[sel][addr[5:0]] = wdata;

    @(negedge clock);
    driveBus(sel, 1'b1, we, addr, wdata);
    @(posedge clock);
    #1 driveBus(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int j = 0; j <= w; j++) begin
      @(negedge clock);
      if (j == 1) driveBus(sel, 1'b0, 1'b0, 8'h00, 8'h00);
      if (glitch && j == 0 && w > 0) driveBus(sel, 1'b1, 1'b1, addr ^ 8'h01, ~wdata);
      checkOutput("ackTiming", 8'(obsAck), 8'((j == w) ? 1 : 0));
      checkOutput("busyDuring", 8'(obsBusy), 8'd1);
      if (j == w) begin
        checkOutput("respRdata", obsRdata, exp);
        checkOutput("respErr", 8'(obsErr), 8'(oor));
      end
    end
    @(negedge clock);
    checkOutput("idleAck", 8'(obsAck), 8'd0);
    checkOutput("idleBusy", 8'(obsBusy), 8'd0);
    checkOutput("idleErr", 8'(obsErr), 8'd0);
    checkOutput("holdRdata", obsRdata, exp);
    lastRdata[sel] = exp;
  endtask

  initial begin
    int         ackCycles[$];
    int         busyLow;
    logic [7:0] exp;

    driveBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    driveBus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    lastRdata[0] = 8'h00;
    lastRdata[1] = 8'h00;

    // Reset state for both instances.
    repeat (3) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      curSel = bit'(s);
      #1;
      checkOutput("rstRdata", obsRdata, 8'h00);
      checkOutput("rstAck", 8'(obsAck), 8'd0);
      checkOutput("rstBusy", 8'(obsBusy), 8'd0);
      checkOutput("rstErr", 8'(obsErr), 8'd0);
    end
    reset = 1'b0;

    // Fill both memories so every later read has a defined expectation.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 64; a++)
        applyStimulus(bit'(s), 1'b1, 8'(a), 8'($urandom), 1'b0);

    applyStimulus(1'b0, 1'b1, 8'd5, 8'hA7, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd5, 8'h00, 1'b0);
    checkOutput("waitRead5", obsRdata, 8'hA7);

    applyStimulus(1'b1, 1'b1, 8'd0, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'h00, 1'b0);
    checkOutput("zeroWaitRead0", obsRdata, 8'h11);

    applyStimulus(1'b0, 1'b1, 8'd6, 8'h42, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd70, 8'hFF, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd70, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd6, 8'h00, 1'b0);
    checkOutput("aliasKeep6", obsRdata, 8'h42);
    applyStimulus(1'b1, 1'b1, 8'd200, 8'hFF, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd255, 8'h00, 1'b0);

    // A request during the wait states must neither queue nor write.
    applyStimulus(1'b0, 1'b1, 8'd13, 8'h31, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'd12, 8'h77, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd12, 8'h00, 1'b1);
    checkOutput("glitchData", obsRdata, 8'h77);
    applyStimulus(1'b0, 1'b0, 8'd13, 8'h00, 1'b0);
    checkOutput("glitchNoWrite", obsRdata, 8'h31);

    // Reset in the middle of a write aborts it and leaves storage alone.
    applyStimulus(1'b0, 1'b1, 8'd9, 8'h5A, 1'b0);
    curSel = 1'b0;
    @(negedge clock);
    driveBus(1'b0, 1'b1, 1'b1, 8'd9, 8'h3C);
    @(posedge clock);
    #1 driveBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    checkOutput("preAbortBusy", 8'(obsBusy), 8'd1);
    reset = 1'b1;
    #1;
    checkOutput("abortBusy", 8'(obsBusy), 8'd0);
    checkOutput("abortRdata", obsRdata, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("abortNoAck", 8'(obsAck), 8'd0);
    end
    reset = 1'b0;
    lastRdata[0] = 8'h00;
    lastRdata[1] = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'd9, 8'h00, 1'b0);
    checkOutput("abortKeep9", obsRdata, 8'h5A);

    // Held request: back-to-back reads with one IDLE cycle between them.
    curSel  = 1'b0;
    exp     = mdl[0][20];
    busyLow = 0;
    @(negedge clock);
    driveBus(1'b0, 1'b1, 1'b0, 8'd20, 8'h00);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (obsAck) begin
        ackCycles.push_back(c);
        checkOutput("heldRdata", obsRdata, exp);
      end
      if (!obsBusy && ackCycles.size() >= 1 && ackCycles.size() < 3) busyLow++;
      if (ackCycles.size() == 3) break;
    end
    driveBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clock);
    lastRdata[0] = exp;
    checkOutput("heldAckCount", 8'(ackCycles.size()), 8'd3);
    if (ackCycles.size() == 3) begin
      checkOutput("heldGap1", 8'(ackCycles[1] - ackCycles[0]), 8'd4);
      checkOutput("heldGap2", 8'(ackCycles[2] - ackCycles[1]), 8'd4);
    end
    checkOutput("heldBusyLow", 8'(busyLow), 8'd2);

    // Randomized traffic including out-of-range addresses.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)),
                    8'($urandom), 1'($urandom_range(0, 1)));
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)),
                    8'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
